// File: rtl/tm_arb_pkg.sv
// tm_arb_pkg
// Shared definitions for the TM1638 frame arbiter.
//   - arb_state_e : sequencing states of the arbiter
//   - DIGIT_BLANK : digit code that the driver renders as a blank digit
//   - TM_DIGITS / TM_DW / FRAME_W : default frame geometry (8 digits x 5 bits)
package tm_arb_pkg;

    localparam int TM_DIGITS   = 8;
    localparam int TM_DW       = 5;
    localparam int FRAME_W     = TM_DIGITS * TM_DW;
    localparam int DIGIT_BLANK = 15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-input round-robin pick. Purely combinational; the caller owns the
// 'last granted' pointer and updates it when it acts on the pick.
// Ports:
//   req0_i, req1_i : requests from source 0 / source 1
//   last_i         : source granted most recently
//   valid_o        : at least one request present
//   win_o          : index of the winning source (meaningful when valid_o)
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic win_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            // Tie: the source that did not win last time goes next.
            win_o = ~last_i;
        end else begin
            win_o = req1_i;
        end
    end

endmodule

// File: rtl/tm1638_frame_arbiter.sv
// tm1638_frame_arbiter
// Shares one TM1638 driver between two frame sources. Round-robin picks a
// requester in IDLE, latches its frame, pulses drv_start, then waits for the
// driver's busy handshake with an acknowledge timeout.
// Optional feature: define ARB_REFRESH_EN to resend the latched frame after
// REFRESH_CYCLES idle cycles without any request.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req0/req1             : frame requests (held until gnt is seen)
//   data0/data1, led0/led1: frame contents, digit 0 in the LSBs
//   gnt0/gnt1             : one-cycle grant pulses
//   drv_start             : one-cycle start pulse to the driver
//   drv_digits, drv_leds  : latched frame presented to the driver
//   drv_busy              : driver shifting a frame
//   owner                 : source of the latched frame
//   done, err             : one-cycle transfer-complete / ack-timeout pulses
module tm1638_frame_arbiter
    import tm_arb_pkg::*;
#(
    parameter int DIGITS         = TM_DIGITS,
    parameter int DW             = TM_DW,
    parameter int ACK_TIMEOUT    = 16,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [DIGITS*DW-1:0] data0,
    input  logic [DIGITS*DW-1:0] data1,
    input  logic [7:0]           led0,
    input  logic [7:0]           led1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 drv_start,
    output logic [DIGITS*DW-1:0] drv_digits,
    output logic [7:0]           drv_leds,
    input  logic                 drv_busy,
    output logic                 owner,
    output logic                 done,
    output logic                 err
);

    localparam int FW    = DIGITS * DW;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    arb_state_e        state_q, state_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [FW-1:0]     digits_q;
    logic [7:0]        leds_q;
    logic              owner_q, last_q;
    logic              gnt0_q, gnt1_q, done_q, err_q;

    logic              arb_valid, arb_win;
    logic              grant_fire, done_fire, err_fire, ack_expired;
    logic              refresh_hit;
    logic [FW-1:0]     blank_frame;

    // Reset image of the digit bus: every digit blank.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            assign blank_frame[gi*DW +: DW] = DW'(DIGIT_BLANK);
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .req0_i  (req0),
        .req1_i  (req1),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .win_o   (arb_win)
    );

`ifdef ARB_REFRESH_EN
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [RF_W-1:0] idle_cnt_q, idle_cnt_d;

    assign refresh_hit = (state_q == ST_IDLE) && !arb_valid &&
                         (idle_cnt_q == RF_W'(REFRESH_CYCLES - 1));

    // Counts only while idle with no request; any request or leaving IDLE
    // restarts the refresh interval.
    always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_IDLE && !arb_valid && !refresh_hit) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    assign ack_expired = (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid || refresh_hit) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d   = ST_WAIT_ACK;
                ack_cnt_d = '0;
            end
            ST_WAIT_ACK: begin
                if (drv_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!drv_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        drv_start  = (state_q == ST_START);
        grant_fire = (state_q == ST_IDLE) && arb_valid;
        err_fire   = (state_q == ST_WAIT_ACK) && !drv_busy && ack_expired;
        done_fire  = (state_q == ST_WAIT_DONE) && !drv_busy;
    end

    // Frame latch and registered pulses. The frame only moves on a grant, so
    // a refresh resends exactly what was last shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= blank_frame;
            leds_q   <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            gnt0_q <= grant_fire && !arb_win;
            gnt1_q <= grant_fire &&  arb_win;
            done_q <= done_fire;
            err_q  <= err_fire;
            if (grant_fire) begin
                digits_q <= arb_win ? data1 : data0;
                leds_q   <= arb_win ? led1  : led0;
                owner_q  <= arb_win;
                last_q   <= arb_win;
            end
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done       = done_q;
    assign err        = err_q;
    assign drv_digits = digits_q;
    assign drv_leds   = leds_q;
    assign owner      = owner_q;

endmodule
